// File: rtl/imgrad_pkg.sv
// Shared types and defaults for the imgrad window sequencer: state encoding,
// coordinate type, default geometry and the determinant singularity threshold.
package imgrad_pkg;

    localparam int WIN_DEFAULT      = 7;
    localparam int ROW_LEN_DEFAULT  = WIN_DEFAULT + 2;
    localparam int PIPE_LAT_DEFAULT = 2;
    localparam int CW_DEFAULT       = 10;

    typedef logic [CW_DEFAULT-1:0] coord_t;

    // Determinants at or below this are reported as singular.
    localparam logic signed [63:0] DET_MIN = 64'sd0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_ROW   = 3'd2,
        ST_GAP   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DET   = 3'd5,
        ST_DONE  = 3'd6
    } imgrad_seq_state_t;

endpackage

// File: rtl/imgrad_det.sv
// Registered 2x2 structure-tensor determinant (ir2*ic2 - iric^2) with a
// singularity flag; loads only while the sequencer sits in its DET state.
module imgrad_det
    import imgrad_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic signed [31:0] ir2,
    input  logic signed [31:0] ic2,
    input  logic signed [31:0] iric,
    output logic signed [63:0] det,
    output logic               singular
);

    logic signed [63:0] det_next;
    logic signed [63:0] det_reg;
    logic               singular_reg;

    // Operands are widened before multiplying so the full signed product survives.
    assign det_next = (64'(ir2) * 64'(ic2)) - (64'(iric) * 64'(iric));

    always_ff @(posedge clk) begin
        if (reset) begin
            det_reg      <= '0;
            singular_reg <= 1'b0;
        end else if (load) begin
            det_reg      <= det_next;
            singular_reg <= (det_next <= DET_MIN);
        end
    end

    assign det      = det_reg;
    assign singular = singular_reg;

endmodule

// File: rtl/imgrad_seq.sv
// Window sequencer for the 7x7 gradient unit: clears imgrad, streams framed rows,
// drains, captures the structure-tensor sums. Optional IMGRAD_SEQ_DET_EN adds DET.
module imgrad_seq
    import imgrad_pkg::*;
#(
    parameter int WIN      = WIN_DEFAULT,
    parameter int ROW_LEN  = WIN + 2,
    parameter int PIPE_LAT = PIPE_LAT_DEFAULT,
    parameter int CW       = CW_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               start_ready,
    input  logic [CW-1:0]      win_row,
    input  logic [CW-1:0]      win_col,
    output logic               rd_en,
    output logic [CW-1:0]      rd_row,
    output logic [CW-1:0]      rd_col,
    output logic               grad_en,
    output logic               grad_rst,
    input  logic signed [31:0] ir2_in,
    input  logic signed [31:0] ic2_in,
    input  logic signed [31:0] iric_in,
    output logic               g_valid,
    input  logic               g_ready,
    output logic signed [31:0] g_ir2,
    output logic signed [31:0] g_ic2,
    output logic signed [31:0] g_iric,
    output logic signed [63:0] g_det,
    output logic               g_singular,
    output logic               busy
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_CLR   = ST_CLR;
    localparam logic [2:0] S_ROW   = ST_ROW;
    localparam logic [2:0] S_GAP   = ST_GAP;
    localparam logic [2:0] S_DRAIN = ST_DRAIN;
    localparam logic [2:0] S_DET   = ST_DET;
    localparam logic [2:0] S_DONE  = ST_DONE;

    localparam int RW = $clog2(WIN + 1);
    localparam int CBW = $clog2(ROW_LEN + 1);
    localparam int DW = $clog2(PIPE_LAT + 1);

    localparam logic [RW-1:0]  R_LAST = RW'(WIN - 1);
    localparam logic [CBW-1:0] C_LAST = CBW'(ROW_LEN - 1);
    localparam logic [DW-1:0]  D_LAST = DW'(PIPE_LAT - 1);

    logic [2:0]     state_reg, state_next;
    logic [RW-1:0]  r_reg, r_next;
    logic [CBW-1:0] c_reg, c_next;
    logic [DW-1:0]  d_reg, d_next;
    logic [CW-1:0]  row_base_reg, row_base_next;
    logic [CW-1:0]  col_base_reg, col_base_next;
    logic           capture_next;

    logic           start_ready_reg, busy_reg, rd_en_reg, grad_en_reg, grad_rst_reg, g_valid_reg;
    logic [CW-1:0]  rd_row_reg, rd_col_reg;
    logic signed [31:0] sum_in  [3];
    logic signed [31:0] sum_reg [3];

    always_comb begin
        state_next    = state_reg;
        r_next        = r_reg;
        c_next        = c_reg;
        d_next        = d_reg;
        row_base_next = row_base_reg;
        col_base_next = col_base_reg;
        capture_next  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    row_base_next = win_row;
                    col_base_next = win_col;
                    r_next        = '0;
                    c_next        = '0;
                    state_next    = S_CLR;
                end
            end
            S_CLR: state_next = S_ROW;
            S_ROW: begin
                if (c_reg == C_LAST) begin
                    if (r_reg == R_LAST) begin
                        d_next     = '0;
                        state_next = S_DRAIN;
                    end else begin
                        state_next = S_GAP;
                    end
                end else begin
                    c_next = c_reg + 1'b1;
                end
            end
            // A dropped enable restarts imgrad's column counter for the next row.
            S_GAP: begin
                r_next     = r_reg + 1'b1;
                c_next     = '0;
                state_next = S_ROW;
            end
            S_DRAIN: begin
                if (d_reg == D_LAST) begin
                    capture_next = 1'b1;
`ifdef IMGRAD_SEQ_DET_EN
                    state_next   = S_DET;
`else
                    state_next   = S_DONE;
`endif
                end else begin
                    d_next = d_reg + 1'b1;
                end
            end
            S_DET:  state_next = S_DONE;
            S_DONE: if (g_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up
    // with state_reg and nothing combinational reaches a port from start/g_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            r_reg           <= '0;
            c_reg           <= '0;
            d_reg           <= '0;
            row_base_reg    <= '0;
            col_base_reg    <= '0;
            start_ready_reg <= 1'b1;
            busy_reg        <= 1'b0;
            rd_en_reg       <= 1'b0;
            grad_en_reg     <= 1'b0;
            grad_rst_reg    <= 1'b0;
            g_valid_reg     <= 1'b0;
            rd_row_reg      <= '0;
            rd_col_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            r_reg           <= r_next;
            c_reg           <= c_next;
            d_reg           <= d_next;
            row_base_reg    <= row_base_next;
            col_base_reg    <= col_base_next;
            start_ready_reg <= (state_next == S_IDLE);
            busy_reg        <= (state_next != S_IDLE);
            rd_en_reg       <= (state_next == S_ROW);
            grad_en_reg     <= (state_next == S_ROW);
            grad_rst_reg    <= (state_next == S_CLR);
            g_valid_reg     <= (state_next == S_DONE);
            if (state_next == S_ROW) begin
                rd_row_reg <= row_base_next + CW'(r_next);
                rd_col_reg <= col_base_next + CW'(c_next);
            end
        end
    end

    assign sum_in[0] = ir2_in;
    assign sum_in[1] = ic2_in;
    assign sum_in[2] = iric_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) sum_reg[i] <= '0;
        end else if (capture_next) begin
            for (int i = 0; i < 3; i++) sum_reg[i] <= sum_in[i];
        end
    end

    assign start_ready = start_ready_reg;
    assign busy        = busy_reg;
    assign rd_en       = rd_en_reg;
    assign grad_en     = grad_en_reg;
    assign grad_rst    = grad_rst_reg;
    assign rd_row      = rd_row_reg;
    assign rd_col      = rd_col_reg;
    assign g_valid     = g_valid_reg;
    assign g_ir2       = sum_reg[0];
    assign g_ic2       = sum_reg[1];
    assign g_iric      = sum_reg[2];

`ifdef IMGRAD_SEQ_DET_EN
    imgrad_det u_det (
        .clk      (clk),
        .reset    (reset),
        .load     (state_reg == S_DET),
        .ir2      (sum_reg[0]),
        .ic2      (sum_reg[1]),
        .iric     (sum_reg[2]),
        .det      (g_det),
        .singular (g_singular)
    );
`else
    assign g_det      = '0;
    assign g_singular = 1'b0;
`endif

endmodule

// File: tb/tb_imgrad_seq.sv
// Randomized directed bench for imgrad_seq: per-cycle framing, address, capture
// and handshake checks against a cycle-index formula model of the window schedule.
module tb_imgrad_seq;
    import imgrad_pkg::*;

    localparam int WIN      = 7;
    localparam int ROW_LEN  = WIN + 2;
    localparam int PIPE_LAT = 2;
    localparam int CW       = 10;
`ifdef IMGRAD_SEQ_DET_EN
    localparam int DET_EXTRA = 1;
`else
    localparam int DET_EXTRA = 0;
`endif
    // Cycle whose closing edge captures the sums, and the cycle g_valid rises.
    localparam int CAP = 1 + WIN * ROW_LEN + (WIN - 1) + PIPE_LAT;
    localparam int LAT = CAP + 1 + DET_EXTRA;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               start_ready;
    logic [CW-1:0]      win_row = '0;
    logic [CW-1:0]      win_col = '0;
    logic               rd_en;
    logic [CW-1:0]      rd_row, rd_col;
    logic               grad_en, grad_rst;
    logic signed [31:0] ir2_in = '0, ic2_in = '0, iric_in = '0;
    logic               g_valid;
    logic               g_ready = 1'b0;
    logic signed [31:0] g_ir2, g_ic2, g_iric;
    logic signed [63:0] g_det;
    logic               g_singular;
    logic               busy;

    int checks = 0;
    int passed = 0;

    imgrad_seq #(.WIN(WIN), .ROW_LEN(ROW_LEN), .PIPE_LAT(PIPE_LAT), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .start_ready(start_ready),
        .win_row(win_row), .win_col(win_col), .rd_en(rd_en), .rd_row(rd_row),
        .rd_col(rd_col), .grad_en(grad_en), .grad_rst(grad_rst),
        .ir2_in(ir2_in), .ic2_in(ic2_in), .iric_in(iric_in),
        .g_valid(g_valid), .g_ready(g_ready), .g_ir2(g_ir2), .g_ic2(g_ic2),
        .g_iric(g_iric), .g_det(g_det), .g_singular(g_singular), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog sim time expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_start_ready"}, 64'(start_ready), 64'(1));
        chk({tag, "_busy"},        64'(busy), 64'(0));
        chk({tag, "_rd_en"},       64'(rd_en), 64'(0));
        chk({tag, "_grad_en"},     64'(grad_en), 64'(0));
        chk({tag, "_grad_rst"},    64'(grad_rst), 64'(0));
        chk({tag, "_g_valid"},     64'(g_valid), 64'(0));
    endtask

    // Schedule model: cycle k after acceptance -> expected framing/address.
    function automatic void sched(input int k, output bit rst_e, output bit en_e,
                                  output int rr, output int cc);
        int t;
        rst_e = (k == 1);
        en_e  = 1'b0;
        rr    = 0;
        cc    = 0;
        if (k >= 2) begin
            t    = k - 2;
            rr   = t / (ROW_LEN + 1);
            cc   = t % (ROW_LEN + 1);
            en_e = (rr < WIN) && (cc < ROW_LEN);
        end
    endfunction

    task automatic garbage_sums();
        ir2_in  = $urandom;
        ic2_in  = $urandom;
        iric_in = $urandom;
    endtask

    task automatic run_window(input int row, input int col, input int ir2, input int ic2,
                              input int iric, input int bp, input int abort_k);
        logic signed [31:0] e_ir2, e_ic2, e_iric;
        logic signed [63:0] e_det;
        bit                 e_sing;
        bit                 rst_e, en_e;
        int                 rr, cc;
        e_ir2  = ir2;
        e_ic2  = ic2;
        e_iric = iric;
`ifdef IMGRAD_SEQ_DET_EN
        e_det  = longint'(ir2) * longint'(ic2) - longint'(iric) * longint'(iric);
        e_sing = (e_det <= DET_MIN);
`else
        e_det  = 0;
        e_sing = 1'b0;
`endif
        chk("start_ready_before_start", 64'(start_ready), 64'(1));
        win_row = CW'(row);
        win_col = CW'(col);
        start   = 1'b1;
        garbage_sums();
        @(posedge clk); #1;
        start   = 1'b0;
        win_row = CW'($urandom);
        win_col = CW'($urandom);
        for (int k = 1; k < LAT; k++) begin
            if (k == abort_k) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                start = 1'b0;
                check_idle("abort");
                $display("window row=%0d col=%0d aborted by reset at cycle %0d", row, col, k);
                return;
            end
            sched(k, rst_e, en_e, rr, cc);
            chk("grad_rst", 64'(grad_rst), 64'(rst_e));
            chk("rd_en", 64'(rd_en), 64'(en_e));
            chk("grad_en", 64'(grad_en), 64'(en_e));
            chk("busy", 64'(busy), 64'(1));
            chk("start_ready_busy", 64'(start_ready), 64'(0));
            chk("g_valid_early", 64'(g_valid), 64'(0));
            if (en_e) begin
                chk("rd_row", 64'(rd_row), 64'((row + rr) % (1 << CW)));
                chk("rd_col", 64'(rd_col), 64'((col + cc) % (1 << CW)));
            end
            start   = 1'($urandom_range(0, 1));
            g_ready = 1'($urandom_range(0, 1));
            if (k == CAP) begin
                ir2_in  = e_ir2;
                ic2_in  = e_ic2;
                iric_in = e_iric;
            end else begin
                garbage_sums();
            end
            @(posedge clk); #1;
        end
        g_ready = 1'b0;
        for (int b = 0; b <= bp; b++) begin
            chk("g_valid", 64'(g_valid), 64'(1));
            chk("g_ir2", 64'(g_ir2), 64'(e_ir2));
            chk("g_ic2", 64'(g_ic2), 64'(e_ic2));
            chk("g_iric", 64'(g_iric), 64'(e_iric));
            chk("g_det", 64'(g_det), 64'(e_det));
            chk("g_singular", 64'(g_singular), 64'(e_sing));
            chk("start_ready_done", 64'(start_ready), 64'(0));
            chk("busy_done", 64'(busy), 64'(1));
            start = 1'($urandom_range(0, 1));
            win_row = CW'($urandom);
            garbage_sums();
            if (b == bp) g_ready = 1'b1;
            @(posedge clk); #1;
        end
        g_ready = 1'b0;
        start   = 1'b0;
        check_idle("after_handshake");
        $display("window row=%0d col=%0d ir2=%0d ic2=%0d iric=%0d det=%0d sing=%0d bp=%0d",
                 row, col, ir2, ic2, iric, e_det, e_sing, bp);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_idle("in_reset");
        reset = 1'b0;
        @(posedge clk); #1;
        check_idle("reset_state");
        chk("reset_g_ir2", 64'(g_ir2), 64'(0));
        chk("reset_g_det", 64'(g_det), 64'(0));
        chk("reset_g_singular", 64'(g_singular), 64'(0));

        run_window(10, 20, 1000, 400, -300, 20, 0);
        run_window(12, 3, 50, 50, 50, 0, 0);
        run_window(5, 5, 7, 8, 9, 0, 30);
        run_window(3, 4, int'($urandom), int'($urandom), int'($urandom), 1, 0);
        run_window(100, 1020, -5, 6, 7, 2, 0);
        run_window(1020, 1019, 20, 30, -40, 0, 0);
        for (int i = 0; i < 4; i++) begin
            run_window(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                       int'($urandom), int'($urandom), int'($urandom),
                       int'($urandom_range(0, 5)), 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
